// File: rtl/etapa_ex_mem_banderas.sv
// ============================================================================
// Module   : etapa_ex_mem_banderas
// Brief    : EX/MEM pipeline register with NZCV flags register, forwarded
//            condition-code evaluation and saturating overflow event counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module etapa_ex_mem_banderas #(
    parameter int n  = 32,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_i,
    input  logic          flush_i,
    input  logic          ex_valid_i,
    input  logic [n-1:0]  ex_result_i,
    input  logic [3:0]    ex_banderas_i,
    input  logic          ex_set_flags_i,
    input  logic          ex_reg_write_i,
    input  logic [3:0]    ex_rd_i,
    input  logic [3:0]    cond_i,
    output logic          cond_pass_o,
    output logic [3:0]    flags_o,
    output logic          mem_valid_o,
    output logic [n-1:0]  mem_result_o,
    output logic [3:0]    mem_rd_o,
    output logic          mem_reg_write_o,
    output logic [CW-1:0] ovf_count_o
);

    localparam logic [CW-1:0] C_CNT_MAX = '1;

    logic          w_commit;
    logic          w_flag_upd;
    logic [3:0]    w_eff;
    logic          w_n, w_z, w_c, w_v;

    logic          mem_valid_q;
    logic [n-1:0]  mem_result_q;
    logic [3:0]    mem_rd_q;
    logic          mem_reg_write_q;
    logic [3:0]    flags_q,   flags_d;
    logic [CW-1:0] ovf_cnt_q, ovf_cnt_d;

    assign w_commit   = ex_valid_i & ~flush_i & ~stall_i;
    assign w_flag_upd = w_commit & ex_set_flags_i;

    // EX/MEM slot: flush kills the slot even while stalled; data may go stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_q     <= 1'b0;
            mem_result_q    <= '0;
            mem_rd_q        <= '0;
            mem_reg_write_q <= 1'b0;
        end else if (flush_i) begin
            mem_valid_q     <= 1'b0;
            mem_reg_write_q <= 1'b0;
        end else if (!stall_i) begin
            mem_valid_q     <= ex_valid_i;
            mem_result_q    <= ex_result_i;
            mem_rd_q        <= ex_rd_i;
            mem_reg_write_q <= ex_valid_i & ex_reg_write_i;
        end
    end

    always_comb begin
        flags_d   = flags_q;
        ovf_cnt_d = ovf_cnt_q;
        if (w_flag_upd) begin
            flags_d = ex_banderas_i;
            if (ex_banderas_i[0] && (ovf_cnt_q != C_CNT_MAX)) begin
                ovf_cnt_d = ovf_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q   <= 4'b0000;
            ovf_cnt_q <= '0;
        end else begin
            flags_q   <= flags_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    // The EX instruction is older than decode, so its flags win even when stalled.
    assign w_eff = (ex_valid_i & ex_set_flags_i & ~flush_i) ? ex_banderas_i : flags_q;
    assign w_n   = w_eff[3];
    assign w_z   = w_eff[2];
    assign w_c   = w_eff[1];
    assign w_v   = w_eff[0];

    always_comb begin
        cond_pass_o = 1'b0;
        case (cond_i)
            4'b0000: cond_pass_o = w_z;
            4'b0001: cond_pass_o = ~w_z;
            4'b0010: cond_pass_o = w_c;
            4'b0011: cond_pass_o = ~w_c;
            4'b0100: cond_pass_o = w_n;
            4'b0101: cond_pass_o = ~w_n;
            4'b0110: cond_pass_o = w_v;
            4'b0111: cond_pass_o = ~w_v;
            4'b1000: cond_pass_o = w_c & ~w_z;
            4'b1001: cond_pass_o = ~w_c | w_z;
            4'b1010: cond_pass_o = (w_n == w_v);
            4'b1011: cond_pass_o = (w_n != w_v);
            4'b1100: cond_pass_o = ~w_z & (w_n == w_v);
            4'b1101: cond_pass_o = w_z | (w_n != w_v);
            4'b1110: cond_pass_o = 1'b1;
            default: cond_pass_o = 1'b0;
        endcase
    end

    assign flags_o         = flags_q;
    assign mem_valid_o     = mem_valid_q;
    assign mem_result_o    = mem_result_q;
    assign mem_rd_o        = mem_rd_q;
    assign mem_reg_write_o = mem_reg_write_q;
    assign ovf_count_o     = ovf_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_etapa_ex_mem_banderas.sv
// ============================================================================
// Module   : tb_etapa_ex_mem_banderas
// Brief    : Directed self-checking bench for etapa_ex_mem_banderas.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_etapa_ex_mem_banderas;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, flush_i, ex_valid_i, ex_set_flags_i, ex_reg_write_i;
    logic [31:0] ex_result_i;
    logic [3:0]  ex_banderas_i, ex_rd_i, cond_i;

    logic        cond_pass_o, mem_valid_o, mem_reg_write_o;
    logic [3:0]  flags_o, mem_rd_o;
    logic [31:0] mem_result_o;
    logic [7:0]  ovf_count_o;

    logic        s_cond_pass, s_mem_valid, s_mem_rw;
    logic [3:0]  s_flags, s_mem_rd;
    logic [31:0] s_mem_result;
    logic [1:0]  s_ovf;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    etapa_ex_mem_banderas #(.n(32), .CW(8)) u_dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .ex_valid_i(ex_valid_i), .ex_result_i(ex_result_i),
        .ex_banderas_i(ex_banderas_i), .ex_set_flags_i(ex_set_flags_i),
        .ex_reg_write_i(ex_reg_write_i), .ex_rd_i(ex_rd_i), .cond_i(cond_i),
        .cond_pass_o(cond_pass_o), .flags_o(flags_o), .mem_valid_o(mem_valid_o),
        .mem_result_o(mem_result_o), .mem_rd_o(mem_rd_o),
        .mem_reg_write_o(mem_reg_write_o), .ovf_count_o(ovf_count_o)
    );

    etapa_ex_mem_banderas #(.n(32), .CW(2)) u_sat (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .ex_valid_i(ex_valid_i), .ex_result_i(ex_result_i),
        .ex_banderas_i(ex_banderas_i), .ex_set_flags_i(ex_set_flags_i),
        .ex_reg_write_i(ex_reg_write_i), .ex_rd_i(ex_rd_i), .cond_i(cond_i),
        .cond_pass_o(s_cond_pass), .flags_o(s_flags), .mem_valid_o(s_mem_valid),
        .mem_result_o(s_mem_result), .mem_rd_o(s_mem_rd),
        .mem_reg_write_o(s_mem_rw), .ovf_count_o(s_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference truth table for the condition field, flags as {N,Z,C,V}.
    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic fn, fz, fc, fv;
        {fn, fz, fc, fv} = f;
        case (c)
            4'h0: return fz;
            4'h1: return !fz;
            4'h2: return fc;
            4'h3: return !fc;
            4'h4: return fn;
            4'h5: return !fn;
            4'h6: return fv;
            4'h7: return !fv;
            4'h8: return fc && !fz;
            4'h9: return !fc || fz;
            4'hA: return fn ~^ fv;
            4'hB: return fn ^ fv;
            4'hC: return !fz && (fn ~^ fv);
            4'hD: return fz || (fn ^ fv);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        rst = 1'b1; stall_i = 0; flush_i = 0; ex_valid_i = 0; ex_set_flags_i = 0;
        ex_reg_write_i = 0; ex_result_i = '0; ex_banderas_i = '0; ex_rd_i = '0; cond_i = '0;
        tick(); tick();
        chk("rst_valid",  mem_valid_o,     0);
        chk("rst_result", mem_result_o,    0);
        chk("rst_rd",     mem_rd_o,        0);
        chk("rst_rw",     mem_reg_write_o, 0);
        chk("rst_flags",  flags_o,         0);
        chk("rst_ovf",    ovf_count_o,     0);

        // Plain load, one-cycle latency
        rst = 0; ex_valid_i = 1; ex_result_i = 32'h12; ex_rd_i = 4'd3; ex_reg_write_i = 1;
        tick();
        chk("load_valid",  mem_valid_o,     1);
        chk("load_result", mem_result_o,    32'h12);
        chk("load_rd",     mem_rd_o,        3);
        chk("load_rw",     mem_reg_write_o, 1);
        chk("load_flags",  flags_o,         4'b0000);

        // Same-cycle flag forwarding
        ex_set_flags_i = 1; ex_banderas_i = 4'b0100; cond_i = 4'b0000;
        #1 chk("fwd_eq", cond_pass_o, 1);
        tick();
        chk("flag_upd", flags_o, 4'b0100);
        ex_valid_i = 0; ex_set_flags_i = 0; cond_i = 4'b0001;
        #1 chk("ne_idle", cond_pass_o, 0);

        // Stall freezes state but still forwards
        ex_valid_i = 1; ex_result_i = 32'h9; ex_rd_i = 4'd5; ex_reg_write_i = 1;
        tick();
        chk("pre_stall_result", mem_result_o, 32'h9);
        stall_i = 1; ex_set_flags_i = 1; ex_banderas_i = 4'b1000; cond_i = 4'b0100;
        ex_result_i = 32'h5; ex_rd_i = 4'd7;
        #1 chk("stall_fwd_mi", cond_pass_o, 1);
        tick(); ex_result_i = 32'h6;
        tick(); ex_result_i = 32'h7;
        tick();
        chk("stall_valid",  mem_valid_o,  1);
        chk("stall_result", mem_result_o, 32'h9);
        chk("stall_rd",     mem_rd_o,     5);
        chk("stall_flags",  flags_o,      4'b0100);
        chk("stall_ovf",    ovf_count_o,  0);

        // Flush while stalled: slot killed, no forwarding, no flag change
        flush_i = 1; ex_banderas_i = 4'b0001; cond_i = 4'b0110;
        #1 chk("flush_nofwd_vs", cond_pass_o, 0);
        tick();
        chk("flush_valid", mem_valid_o,     0);
        chk("flush_rw",    mem_reg_write_o, 0);
        chk("flush_flags", flags_o,         4'b0100);
        chk("flush_ovf",   ovf_count_o,     0);
        flush_i = 0; stall_i = 0;

        // Full condition sweep over every flag value
        for (int f = 0; f < 16; f++) begin
            ex_valid_i = 1; ex_set_flags_i = 1; ex_banderas_i = f[3:0];
            tick();
            ex_valid_i = 0; ex_set_flags_i = 0; ex_banderas_i = ~f[3:0];
            chk("sweep_flags", flags_o, f);
            for (int c = 0; c < 16; c++) begin
                cond_i = c[3:0];
                #1 chk($sformatf("cond_f%0h_c%0h", f, c), cond_pass_o, cond_ref(c[3:0], f[3:0]));
            end
            if (f == 8) begin
                cond_i = 4'b1010; #1 chk("n1v0_ge", cond_pass_o, 0);
                cond_i = 4'b1011; #1 chk("n1v0_lt", cond_pass_o, 1);
                cond_i = 4'b1100; #1 chk("n1v0_gt", cond_pass_o, 0);
                cond_i = 4'b1101; #1 chk("n1v0_le", cond_pass_o, 1);
            end
        end
        chk("sweep_ovf8", ovf_count_o, 8);
        chk("sweep_ovf2", s_ovf,       3);

        // Saturation on the 2-bit counter
        rst = 1; tick(); rst = 0;
        chk("sat_rst", s_ovf, 0);
        ex_valid_i = 1; ex_set_flags_i = 1; ex_banderas_i = 4'b0001;
        tick(); chk("sat_1", s_ovf, 1);
        tick(); chk("sat_2", s_ovf, 2);
        tick(); chk("sat_3", s_ovf, 3);
        tick(); chk("sat_hold", s_ovf, 3);
        chk("nosat_4", ovf_count_o, 4);
        ex_banderas_i = 4'b0000;
        tick(); chk("sat_v0", s_ovf, 3);
        chk("pre_rst_valid", mem_valid_o, 1);

        // Reset wins over an active stall
        stall_i = 1; rst = 1;
        tick();
        chk("rst_stall_ovf",   s_ovf,       0);
        chk("rst_stall_valid", mem_valid_o, 0);
        chk("rst_stall_flags", flags_o,     0);
        rst = 0; stall_i = 0; ex_valid_i = 0; ex_set_flags_i = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
